// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encoding
// and the sizing helper for the return-stack occupancy counter.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_JMP = 2'd2,
        SEL_RET = 2'd3
    } pc_sel_e;

    // Counter must represent 0..depth inclusive.
    function automatic int ras_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_unit_return_stack.sv
// Circular return-address stack: a full stack overwrites its oldest entry on
// push, and the count saturates at DEPTH.
module return_stack
    import pc_unit_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DW-1:0]                push_data,
    output logic [DW-1:0]                top,
    output logic [ras_cnt_w(DEPTH)-1:0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = ras_cnt_w(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_sp;
    logic [CW-1:0] r_count;

    // Entry storage; deliberately not reset, entries above count are unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_sp] <= push_data;
        end
    end

    // Pointer and occupancy; the pointer wraps so a full push lands on the oldest slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp    <= '0;
            r_count <= '0;
        end else if (push) begin
            r_sp <= r_sp + PW'(1);
            if (r_count != CW'(DEPTH)) begin
                r_count <= r_count + CW'(1);
            end
        end else if (pop && (r_count != '0)) begin
            r_sp    <= r_sp - PW'(1);
            r_count <= r_count - CW'(1);
        end
    end

    assign top   = r_mem[r_sp - PW'(1)];
    assign count = r_count;

endmodule

// File: rtl/pc_unit.sv
// Program counter with prioritised redirects (ret > jump > branch > sequential),
// call/return stack, target alignment and one-cycle status pulses.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INST_BYTES   = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             pc_write,
    input  logic                             branch_taken,
    input  logic [XLEN-1:0]                  branch_target,
    input  logic                             jump,
    input  logic                             call,
    input  logic [XLEN-1:0]                  jump_target,
    input  logic                             ret,
    output logic [XLEN-1:0]                  pc,
    output logic [XLEN-1:0]                  pc_plus,
    output logic [ras_cnt_w(RAS_DEPTH)-1:0]  ras_count,
    output logic                             ras_underflow,
    output logic                             misaligned
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

    logic [XLEN-1:0]                 r_pc;
    logic                            r_underflow;
    logic                            r_misaligned;
    pc_sel_e                         w_sel;
    logic [XLEN-1:0]                 w_raw_target;
    logic [XLEN-1:0]                 w_next_pc;
    logic [XLEN-1:0]                 w_pc_plus;
    logic [XLEN-1:0]                 w_ras_top;
    logic [ras_cnt_w(RAS_DEPTH)-1:0] w_ras_count;
    logic                            w_ras_empty;
    logic                            w_push;
    logic                            w_pop;
    logic                            w_redirect;

    assign w_pc_plus   = r_pc + XLEN'(INST_BYTES);
    assign w_ras_empty = (w_ras_count == '0);

    // Priority select of the next-PC source and its raw target.
    always_comb begin
        w_sel        = SEL_SEQ;
        w_raw_target = w_pc_plus;
        if (ret) begin
            w_sel = SEL_RET;
        end else if (jump) begin
            w_sel = SEL_JMP;
        end else if (branch_taken) begin
            w_sel = SEL_BR;
        end else begin
            w_sel = SEL_SEQ;
        end
        case (w_sel)
            SEL_RET: w_raw_target = w_ras_empty ? jump_target : w_ras_top;
            SEL_JMP: w_raw_target = jump_target;
            SEL_BR:  w_raw_target = branch_target;
            SEL_SEQ: w_raw_target = w_pc_plus;
            default: w_raw_target = w_pc_plus;
        endcase
    end

    assign w_redirect = (w_sel != SEL_SEQ);
    assign w_next_pc  = w_redirect ? (w_raw_target & ~ALIGN_MASK) : w_pc_plus;
    assign w_push     = pc_write && (w_sel == SEL_JMP) && call;
    assign w_pop      = pc_write && (w_sel == SEL_RET);

    return_stack #(
        .DW    (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_plus),
        .top       (w_ras_top),
        .count     (w_ras_count)
    );

    // PC register and status pulses; a stall clears the pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_VECTOR;
            r_underflow  <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (pc_write) begin
            r_pc         <= w_next_pc;
            r_underflow  <= (w_sel == SEL_RET) && w_ras_empty;
            r_misaligned <= w_redirect && ((w_raw_target & ALIGN_MASK) != '0);
        end else begin
            r_underflow  <= 1'b0;
            r_misaligned <= 1'b0;
        end
    end

    assign pc            = r_pc;
    assign pc_plus       = w_pc_plus;
    assign ras_count     = w_ras_count;
    assign ras_underflow = r_underflow;
    assign misaligned    = r_misaligned;

endmodule
